// File: rtl/tproc_fetch_pkg.sv
// Purpose: shared types and constants for the feature fetch path.
//   state_t        : fetcher FSM states
//   FT_STRIDE_LSB  : position of the 2-bit stride field inside fetch_type
//   DEF_*          : default widths used by feature_fetcher parameters
`timescale 1ns/1ps
package tproc_fetch_pkg;

  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_SRC_AW    = 16;
  localparam int unsigned DEF_DST_AW    = 8;
  localparam int unsigned DEF_NUM_BANKS = 4;

  localparam int unsigned FT_STRIDE_LSB = 2;
  localparam int unsigned FT_STRIDE_W   = 2;
  localparam int unsigned STRIDE_W      = 3;   // stride value 1..4
  localparam int unsigned CNT_W         = 9;   // issued / received counters

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/feature_fetcher.sv
// Purpose: executes one feature-fetch command: streams N (strided) source
// words into a feature buffer bank, then pulses done.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   fetch_enable                  : command strobe, started on its rising edge
//   fetch_type/src_addr/dst_addr  : stride field, first source / buffer address
//   mem_sel, fetch_counter        : target bank, word count (0 = none)
//   src_rd_*                      : source read request / in-order response
//   buf_wr_*                      : one-hot bank write port
//   busy, done, err               : status (err sticky until next command)
`timescale 1ns/1ps
module feature_fetcher
  import tproc_fetch_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned SRC_AW    = DEF_SRC_AW,
  parameter int unsigned DST_AW    = DEF_DST_AW,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_enable,
  input  logic [7:0]           fetch_type,
  input  logic [SRC_AW-1:0]    src_addr,
  input  logic [DST_AW-1:0]    dst_addr,
  input  logic [7:0]           mem_sel,
  input  logic [7:0]           fetch_counter,
  output logic                 src_rd_en,
  output logic [SRC_AW-1:0]    src_rd_addr,
  input  logic                 src_rd_ready,
  input  logic                 src_rd_valid,
  input  logic [DATA_W-1:0]    src_rd_data,
  output logic [NUM_BANKS-1:0] buf_wr_en,
  output logic [DST_AW-1:0]    buf_wr_addr,
  output logic [DATA_W-1:0]    buf_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  state_t                r_state, w_state_nxt;
  logic                  r_fe_d;
  logic                  r_src_rd_en, w_src_rd_en_nxt;
  logic [SRC_AW-1:0]     r_src_rd_addr, w_src_rd_addr_nxt;
  logic [CNT_W-1:0]      r_iss, w_iss_nxt;
  logic [CNT_W-1:0]      r_rcv, w_rcv_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;

  // Latched command fields
  logic [7:0]            r_cnt;
  logic [STRIDE_W-1:0]   r_stride;
  logic [BANK_W-1:0]     r_bank;
  logic                  r_bad;
  logic [DST_AW-1:0]     r_dst_cnt;

  logic [NUM_BANKS-1:0]  r_buf_wr_en;
  logic [DST_AW-1:0]     r_buf_wr_addr;
  logic [DATA_W-1:0]     r_buf_wr_data;

  logic                  w_start;
  logic                  w_acc;
  logic                  w_rsp;
  logic                  w_bad_bank;
  logic [CNT_W-1:0]      w_n;
  logic                  w_unused_ok;

  assign w_unused_ok = &{1'b0, fetch_type[7:FT_STRIDE_LSB+FT_STRIDE_W],
                         fetch_type[FT_STRIDE_LSB-1:0]};

  assign w_n        = CNT_W'(r_cnt);
  assign w_bad_bank = (mem_sel >= 8'(NUM_BANKS));
  // Rising edge only, and only while idle; edges elsewhere are dropped
  assign w_start    = fetch_enable & ~r_fe_d & (r_state == S_IDLE);
  assign w_acc      = r_src_rd_en & src_rd_ready & (r_state == S_ISSUE);
  // Responses count only while a command is collecting them
  assign w_rsp      = src_rd_valid & ((r_state == S_ISSUE) || (r_state == S_DRAIN))
                      & (r_rcv < w_n);

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt       = r_state;
    w_src_rd_addr_nxt = r_src_rd_addr;
    w_iss_nxt         = r_iss;
    w_rcv_nxt         = r_rcv + CNT_W'(w_rsp);
    w_err_nxt         = r_err;
    w_done_nxt        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_err_nxt         = 1'b0;
          w_iss_nxt         = '0;
          w_rcv_nxt         = '0;
          w_src_rd_addr_nxt = src_addr;
          if (w_bad_bank || (fetch_counter == 8'd0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_acc) begin
          w_src_rd_addr_nxt = r_src_rd_addr + SRC_AW'(r_stride);
          w_iss_nxt         = r_iss + CNT_W'(1);
          if ((r_iss + CNT_W'(1)) == w_n) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Include this cycle's response so DONE follows the last write directly
        if (w_rcv_nxt == w_n) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        if (r_bad) begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_src_rd_en_nxt = (w_state_nxt == S_ISSUE);
  end

  // State, counters, command latch and write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fe_d        <= 1'b0;
      r_src_rd_en   <= 1'b0;
      r_src_rd_addr <= '0;
      r_iss         <= '0;
      r_rcv         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_cnt         <= '0;
      r_stride      <= '0;
      r_bank        <= '0;
      r_bad         <= 1'b0;
      r_dst_cnt     <= '0;
      r_buf_wr_en   <= '0;
      r_buf_wr_addr <= '0;
      r_buf_wr_data <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fe_d        <= fetch_enable;
      r_src_rd_en   <= w_src_rd_en_nxt;
      r_src_rd_addr <= w_src_rd_addr_nxt;
      r_iss         <= w_iss_nxt;
      r_rcv         <= w_rcv_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;

      if (w_start) begin
        r_cnt     <= fetch_counter;
        r_stride  <= STRIDE_W'(fetch_type[FT_STRIDE_LSB +: FT_STRIDE_W]) + STRIDE_W'(1);
        r_bank    <= BANK_W'(mem_sel);
        r_bad     <= w_bad_bank;
        r_dst_cnt <= dst_addr;
      end

      if (w_rsp) begin
        r_buf_wr_en   <= NUM_BANKS'(1) << r_bank;
        r_buf_wr_addr <= r_dst_cnt;
        r_buf_wr_data <= src_rd_data;
        r_dst_cnt     <= r_dst_cnt + DST_AW'(1);
      end else begin
        r_buf_wr_en   <= '0;
      end
    end
  end

  assign src_rd_en   = r_src_rd_en;
  assign src_rd_addr = r_src_rd_addr;
  assign buf_wr_en   = r_buf_wr_en;
  assign buf_wr_addr = r_buf_wr_addr;
  assign buf_wr_data = r_buf_wr_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: doc/feature_fetcher.md
# feature_fetcher

Executes feature-fetch commands from `instruction_decode`. It streams a contiguous or strided block of 64-bit words from the shared source memory into one of the on-chip feature buffer banks. It sits directly downstream of the decoder, consuming `fetch_type`, `src_addr`, `dst_addr`, `mem_sel` and `fetch_counter`, and reports `busy`/`done` for instruction sequencing.

## Interface
Parameters:
- `DATA_W`, 64: word width, source and buffer.
- `SRC_AW`, 16: source address width.
- `DST_AW`, 8: buffer address width.
- `NUM_BANKS`, 4: feature buffer banks; valid `mem_sel` is 0..NUM_BANKS-1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `fetch_enable`, in, 1: `feature_fetch_enable` from the decoder.
- `fetch_type`, in, 8: bits [3:2] select source stride (value+1 = 1..4 words). Other bits are ignored.
- `src_addr`, in, SRC_AW: first source word address.
- `dst_addr`, in, DST_AW: first buffer word address.
- `mem_sel`, in, 8: target bank index.
- `fetch_counter`, in, 8: number of words to transfer; 0 means none.
- `src_rd_en`, out, 1: source read request.
- `src_rd_addr`, out, SRC_AW: source read address.
- `src_rd_ready`, in, 1: source accepts a request this cycle.
- `src_rd_valid`, in, 1: read data valid; responses return in request order.
- `src_rd_data`, in, DATA_W: read data.
- `buf_wr_en`, out, NUM_BANKS: one-hot bank write strobe.
- `buf_wr_addr`, out, DST_AW: buffer write address.
- `buf_wr_data`, out, DATA_W: buffer write data.
- `busy`, out, 1: command in progress.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: sticky flag set by an invalid bank. Cleared by the next accepted command.

## Operation
- All outputs are registered. Reset values: `src_rd_en`, `buf_wr_en`, `busy`, `done` and `err` are 0. `src_rd_addr`, `buf_wr_addr` and `buf_wr_data` are 0.
- Start: a command starts on a rising edge of `fetch_enable` (high now, low last cycle) while in IDLE. All fields are latched at that edge.
  - A rising edge outside IDLE is dropped.
  - Holding `fetch_enable` high does not retrigger.
- FSM states:
  - IDLE: on start, go to ISSUE. If `fetch_counter`==0, go straight to DONE instead. If `mem_sel`>=NUM_BANKS, set `err` and go to DONE.
  - ISSUE: assert `src_rd_en` with the current address. When `src_rd_en && src_rd_ready`, the request is accepted: address += stride and issued count += 1. After the N-th acceptance, go to DRAIN. `src_rd_en` stays high while unaccepted, with the address held.
  - DRAIN: wait until received count == N, then go to DONE.
  - DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- Writes:
  - Each `src_rd_valid` accepted in ISSUE or DRAIN produces, next cycle, `buf_wr_en[bank]`=1, `buf_wr_addr`=dst counter and `buf_wr_data`=data.
  - The dst counter then increments by 1.
  - `src_rd_valid` in IDLE or DONE is ignored.
- Arithmetic:
  - Source address wraps modulo 2^SRC_AW.
  - Buffer address wraps modulo 2^DST_AW (0xFF→0x00).
  - Issued and received counters are 9 bits wide.

## Timing
- Start edge sampled at cycle k: `busy`=1 and `src_rd_en`=1 from k+1.
- With `src_rd_ready` held high, one request is accepted per cycle.
- Write latency: `src_rd_valid` at cycle j gives `buf_wr_en` at j+1.
- `done` appears on the cycle after the final `buf_wr_en`. `busy` is low in that same cycle.
- Zero-count or bad-bank command: `done` at k+2 with no reads or writes. For a bad bank, `err`=1 from k+2.
- Reset mid-command: the next cycle is IDLE with all outputs at reset values. Later in-flight responses are ignored.
- A response arriving in the same cycle as an acceptance is handled in parallel; no cycle is lost.

## Structure
- Shared package `tproc_fetch_pkg`: FSM state enum (IDLE, ISSUE, DRAIN, DONE), the stride field position `FT_STRIDE_LSB`=2, and default widths.
- Single module; no sub-module. The start edge detector is a local register.

## Test plan
- Basic transfer: `src_addr`=0x0100, `dst_addr`=0x10, `mem_sel`=2, count=4, stride 1, latency 2, ready=1. Expect reads 0x0100..0x0103, then bank-2 writes to 0x10..0x13 with matching data. `done` comes 1 cycle after the last write.
- Stride and wrap: `fetch_type`=0x04 (stride 2), src=0xFFFE, dst=0xFE, count=3. Expect reads 0xFFFE, 0x0000, 0x0002 and writes to 0xFE, 0xFF, 0x00.
- Backpressure: `src_rd_ready` toggles 1,0,0,1 with count=4. Expect `src_rd_addr` held while not ready, exactly 4 accepted requests and 4 writes in order.
- Degenerate commands:
  - count=0: `done` at k+2, no strobes, `err`=0.
  - `mem_sel`=5: `done` at k+2 and `err`=1. `err` clears on the next valid command.
- Retrigger rules: `fetch_enable` held high for 10 cycles gives exactly one command. A second rising edge while busy is dropped.
- Reset during DRAIN: assert `rst` for 1 cycle. Expect `busy`=0 and no `buf_wr_en` from late `src_rd_valid`; a new command then runs normally.
